mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Stores complete in the accept cycle; loads hold the port for one response cycle.
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_0,
  input  logic              req_valid_1,
  input  logic              req_write_0,
  input  logic              req_write_1,
  input  logic [ADDR_W-1:0] req_addr_0,
  input  logic [ADDR_W-1:0] req_addr_1,
  input  logic [DATA_W-1:0] req_wdata_0,
  input  logic [DATA_W-1:0] req_wdata_1,
  output logic              req_ready_0,
  output logic              req_ready_1,
  output logic              rsp_valid_0,
  output logic              rsp_valid_1,
  output logic [DATA_W-1:0] rsp_rdata_0,
  output logic [DATA_W-1:0] rsp_rdata_1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic {S_IDLE, S_RD_WAIT} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_last_grant;
  logic              r_rsp_id;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rdata_0;
  logic [DATA_W-1:0] r_rdata_1;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_idle;
  logic              w_conflict;
  logic              w_accept;
  logic              w_winner;
  logic              w_win_write;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;

  // Gating with rst keeps every ready/strobe low while reset is held.
  assign w_idle      = (r_state == S_IDLE) && rst;
  assign w_conflict  = w_idle && req_valid_0 && req_valid_1;
  assign w_accept    = w_idle && (req_valid_0 || req_valid_1);
  assign w_winner    = w_conflict ? ~r_last_grant : req_valid_1;
  assign w_win_write = w_winner ? req_write_1 : req_write_0;
  assign w_win_addr  = w_winner ? req_addr_1  : req_addr_0;
  assign w_win_wdata = w_winner ? req_wdata_1 : req_wdata_0;

  assign conflict_cnt = r_cnt;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    w_next_state = r_state;
    req_ready_0  = 1'b0;
    req_ready_1  = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = r_mem_addr;
    mem_wdata    = r_mem_wdata;
    rsp_valid_0  = 1'b0;
    rsp_valid_1  = 1'b0;
    rsp_rdata_0  = r_rdata_0;
    rsp_rdata_1  = r_rdata_1;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          req_ready_0 = ~w_winner;
          req_ready_1 = w_winner;
          mem_write   = w_win_write;
          mem_read    = ~w_win_write;
          mem_addr    = w_win_addr;
          mem_wdata   = w_win_wdata;
          if (!w_win_write) w_next_state = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        w_next_state = S_IDLE;
        if (r_rsp_id) begin
          rsp_valid_1 = 1'b1;
          rsp_rdata_1 = mem_rdata;
        end else begin
          rsp_valid_0 = 1'b1;
          rsp_rdata_0 = mem_rdata;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_rsp_id     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_rdata_0    <= '0;
      r_rdata_1    <= '0;
      r_cnt        <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state <= w_next_state;
      if (w_accept) begin
        r_last_grant <= w_winner;
        r_rsp_id     <= w_winner;
        r_mem_addr   <= w_win_addr;
        r_mem_wdata  <= w_win_wdata;
      end
      if (r_state == S_RD_WAIT) begin
        if (r_rsp_id) r_rdata_1 <= mem_rdata;
        else          r_rdata_0 <= mem_rdata;
      end
      if (w_conflict && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: reset checks, a vector table,
// directed multi-cycle sequences, and randomized traffic against a transaction model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          v0, v1, w0, w1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;
  logic          req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1;
  logic [DW-1:0] rsp_rdata_0, rsp_rdata_1;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [CW-1:0] conflict_cnt;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_0(v0), .req_valid_1(v1),
    .req_write_0(w0), .req_write_1(w1),
    .req_addr_0(a0), .req_addr_1(a1),
    .req_wdata_0(d0), .req_wdata_1(d1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_rdata_0(rsp_rdata_0), .rsp_rdata_1(rsp_rdata_1),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic          v0, v1, wr0, wr1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] rdata;
    logic          e_r0, e_r1, e_rd, e_wr, e_rv0, e_rv1;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_rd0, e_rd1;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    v0 = 1'b0; v1 = 1'b0; w0 = 1'b0; w1 = 1'b0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".ready0"}, req_ready_0, 0);
    check({tag, ".ready1"}, req_ready_1, 0);
    check({tag, ".rsp_valid0"}, rsp_valid_0, 0);
    check({tag, ".rsp_valid1"}, rsp_valid_1, 0);
    check({tag, ".rsp_rdata0"}, rsp_rdata_0, 0);
    check({tag, ".rsp_rdata1"}, rsp_rdata_1, 0);
    check({tag, ".mem_read"}, mem_read, 0);
    check({tag, ".mem_write"}, mem_write, 0);
    check({tag, ".mem_addr"}, mem_addr, 0);
    check({tag, ".mem_wdata"}, mem_wdata, 0);
    check({tag, ".conflict_cnt"}, conflict_cnt, 0);
  endtask

  task automatic rand_phase(input int ncyc);
    int            m_last;
    int            m_cnt;
    int            pend;
    int            win;
    bit            conflict;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rd[2];
    bit            h[2];
    logic          rw[2];
    logic [AW-1:0] ra[2];
    logic [DW-1:0] rdd[2];
    int            wait_ops[2];
    logic          e_rv[2];
    logic [DW-1:0] e_rdv[2];
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    m_last = 1; m_cnt = 0; pend = -1;
    m_addr = '0; m_wdata = '0;
    for (int i = 0; i < 2; i++) begin
      m_rd[i] = '0; h[i] = 1'b0; wait_ops[i] = 0;
      rw[i] = 1'b0; ra[i] = '0; rdd[i] = '0;
    end
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!h[i]) begin
          h[i]   = ($urandom_range(0, 99) < 65);
          rw[i]  = 1'($urandom_range(0, 1));
          ra[i]  = $urandom;
          rdd[i] = $urandom;
        end
      end
      v0 = h[0]; w0 = rw[0]; a0 = ra[0]; d0 = rdd[0];
      v1 = h[1]; w1 = rw[1]; a1 = ra[1]; d1 = rdd[1];
      mem_rdata = $urandom;

      win = -1;
      conflict = 1'b0;
      for (int i = 0; i < 2; i++) begin
        e_rv[i]  = 1'b0;
        e_rdv[i] = m_rd[i];
      end
      if (pend >= 0) begin
        e_rv[pend]  = 1'b1;
        e_rdv[pend] = mem_rdata;
      end else if (h[0] && h[1]) begin
        conflict = 1'b1;
        win = 1 - m_last;
      end else if (h[0]) begin
        win = 0;
      end else if (h[1]) begin
        win = 1;
      end
      e_addr  = (win >= 0) ? ra[win]  : m_addr;
      e_wdata = (win >= 0) ? rdd[win] : m_wdata;

      @(negedge clk);
      check("rand.ready0", req_ready_0, win == 0);
      check("rand.ready1", req_ready_1, win == 1);
      check("rand.mem_read", mem_read, (win >= 0) && !rw[win]);
      check("rand.mem_write", mem_write, (win >= 0) && rw[win]);
      check("rand.mem_addr", mem_addr, e_addr);
      check("rand.mem_wdata", mem_wdata, e_wdata);
      check("rand.rsp_valid0", rsp_valid_0, e_rv[0]);
      check("rand.rsp_valid1", rsp_valid_1, e_rv[1]);
      check("rand.rsp_rdata0", rsp_rdata_0, e_rdv[0]);
      check("rand.rsp_rdata1", rsp_rdata_1, e_rdv[1]);
      check("rand.conflict_cnt", conflict_cnt, 64'(m_cnt));

      if (pend >= 0) begin
        m_rd[pend] = mem_rdata;
        pend = -1;
      end
      if (win >= 0) begin
        check("rand.starvation", wait_ops[win] <= 1, 1);
        for (int i = 0; i < 2; i++)
          if (i != win && h[i]) wait_ops[i]++;
        m_last  = win;
        m_addr  = ra[win];
        m_wdata = rdd[win];
        if (!rw[win]) pend = win;
        h[win] = 1'b0;
        wait_ops[win] = 0;
      end
      if (conflict && m_cnt < (2 ** CW) - 1) m_cnt++;
      next_cycle();
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 32'h200, 32'h1111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0,  32'h0,  4'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h104, 32'h200, 32'h2222, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0,  32'h0,  4'd1};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,   32'h204, 32'h3333, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h204, 32'h0,  32'h0,  4'd2};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h4444, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h204, 32'h0,  32'h0,  4'd2};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0,   32'h5555, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0,  32'h0,  4'd2};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h400, 32'h208, 32'hAA,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 32'hAA, 32'h0,  4'd2};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h400, 32'h208, 32'h6666, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h208, 32'hAA, 32'h0,  4'd2};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h400, 32'h500, 32'h7777, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h400, 32'hAA, 32'h0,  4'd3};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h500, 32'h8888, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h500, 32'hAA, 32'h0,  4'd4};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h77,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h500, 32'hAA, 32'h77, 4'd4};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h9999, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h500, 32'hAA, 32'h77, 4'd4};

    // Reset held with both requesters asking: everything must read zero.
    idle_inputs();
    mem_rdata = '0;
    v0 = 1'b1; v1 = 1'b1; a0 = 32'h44; a1 = 32'h88; d0 = 32'h1; d1 = 32'h2;
    #3;
    check_zero("reset");
    next_cycle();
    rst = 1'b1;

    // First accept right after release: single load from requester 0.
    v1 = 1'b0; w0 = 1'b0; a0 = 32'h8;
    @(negedge clk);
    check("first.ready0", req_ready_0, 1);
    check("first.ready1", req_ready_1, 0);
    check("first.mem_read", mem_read, 1);
    check("first.mem_write", mem_write, 0);
    check("first.mem_addr", mem_addr, 32'h8);
    next_cycle();
    v0 = 1'b0;
    mem_rdata = 32'h55;
    @(negedge clk);
    check("first.rsp_valid0", rsp_valid_0, 1);
    check("first.rsp_valid1", rsp_valid_1, 0);
    check("first.rsp_rdata0", rsp_rdata_0, 32'h55);
    check("first.ready0_rdwait", req_ready_0, 0);
    check("first.mem_read_rdwait", mem_read, 0);
    next_cycle();
    mem_rdata = 32'h99;
    @(negedge clk);
    check("first.rsp_valid0_after", rsp_valid_0, 0);
    check("first.rsp_rdata0_hold", rsp_rdata_0, 32'h55);
    next_cycle();

    // Vector table, starting from a fresh reset.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      logic [DW-1:0] exp_wd;
      v0 = vecs[i].v0; v1 = vecs[i].v1; w0 = vecs[i].wr0; w1 = vecs[i].wr1;
      a0 = vecs[i].a0; a1 = vecs[i].a1; d0 = ~vecs[i].a0; d1 = ~vecs[i].a1;
      mem_rdata = vecs[i].rdata;
      exp_wd = ~vecs[i].e_addr;
      @(negedge clk);
      check($sformatf("vec%0d.ready0", i), req_ready_0, vecs[i].e_r0);
      check($sformatf("vec%0d.ready1", i), req_ready_1, vecs[i].e_r1);
      check($sformatf("vec%0d.mem_read", i), mem_read, vecs[i].e_rd);
      check($sformatf("vec%0d.mem_write", i), mem_write, vecs[i].e_wr);
      check($sformatf("vec%0d.mem_addr", i), mem_addr, vecs[i].e_addr);
      check($sformatf("vec%0d.mem_wdata", i), mem_wdata, exp_wd);
      check($sformatf("vec%0d.rsp_valid0", i), rsp_valid_0, vecs[i].e_rv0);
      check($sformatf("vec%0d.rsp_valid1", i), rsp_valid_1, vecs[i].e_rv1);
      check($sformatf("vec%0d.rsp_rdata0", i), rsp_rdata_0, vecs[i].e_rd0);
      check($sformatf("vec%0d.rsp_rdata1", i), rsp_rdata_1, vecs[i].e_rd1);
      check($sformatf("vec%0d.conflict_cnt", i), conflict_cnt, vecs[i].e_cnt);
      next_cycle();
    end

    // Both requesters loading continuously: grants alternate 0,1,0,1...
    do_reset();
    v0 = 1'b1; v1 = 1'b1; w0 = 1'b0; w1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      a0 = 32'(32'h1000 + k * 8);
      a1 = 32'(32'h2000 + k * 8);
      @(negedge clk);
      check($sformatf("rr%0d.ready0", k), req_ready_0, (k % 2) == 0);
      check($sformatf("rr%0d.ready1", k), req_ready_1, (k % 2) == 1);
      check($sformatf("rr%0d.mem_read", k), mem_read, 1);
      check($sformatf("rr%0d.mem_addr", k), mem_addr, (k % 2) == 0 ? a0 : a1);
      check($sformatf("rr%0d.cnt_accept", k), conflict_cnt, 64'(k));
      next_cycle();
      mem_rdata = 32'(32'hC0 + k);
      @(negedge clk);
      check($sformatf("rr%0d.rsp_valid0", k), rsp_valid_0, (k % 2) == 0);
      check($sformatf("rr%0d.rsp_valid1", k), rsp_valid_1, (k % 2) == 1);
      check($sformatf("rr%0d.rsp_rdata", k), (k % 2) == 0 ? rsp_rdata_0 : rsp_rdata_1, 32'(32'hC0 + k));
      check($sformatf("rr%0d.no_ready", k), {req_ready_0, req_ready_1, mem_read}, 0);
      check($sformatf("rr%0d.cnt_rdwait", k), conflict_cnt, 64'(k + 1));
      next_cycle();
    end

    // Back-to-back stores from requester 1.
    v0 = 1'b0; v1 = 1'b1; w1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a1 = 32'(k * 8);
      d1 = 32'(32'hA0 + k);
      @(negedge clk);
      check($sformatf("st%0d.mem_write", k), mem_write, 1);
      check($sformatf("st%0d.ready1", k), req_ready_1, 1);
      check($sformatf("st%0d.mem_addr", k), mem_addr, 64'(k * 8));
      check($sformatf("st%0d.mem_wdata", k), mem_wdata, 64'(32'hA0 + k));
      check($sformatf("st%0d.rsp_valid", k), {rsp_valid_0, rsp_valid_1}, 0);
      next_cycle();
    end
    v1 = 1'b0;
    @(negedge clk);
    check("st.idle_write", mem_write, 0);
    check("st.idle_rsp", {rsp_valid_0, rsp_valid_1}, 0);
    check("st.addr_hold", mem_addr, 32'h10);
    next_cycle();

    // Reset asserted in the response cycle aborts the load.
    v0 = 1'b1; w0 = 1'b0; a0 = 32'h40;
    @(negedge clk);
    check("abort.ready0", req_ready_0, 1);
    next_cycle();
    v0 = 1'b0;
    mem_rdata = 32'h1234;
    #2;
    rst = 1'b0;
    #1;
    check_zero("abort");
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("abort.no_rsp", {rsp_valid_0, rsp_valid_1}, 0);
    next_cycle();
    v0 = 1'b1; v1 = 1'b1; w0 = 1'b1; w1 = 1'b1;
    @(negedge clk);
    check("abort.win0_ready0", req_ready_0, 1);
    check("abort.win0_ready1", req_ready_1, 0);
    check("abort.no_rsp2", {rsp_valid_0, rsp_valid_1}, 0);
    next_cycle();

    // Conflict counter saturation at 2^CW-1.
    do_reset();
    v0 = 1'b1; v1 = 1'b1; w0 = 1'b1; w1 = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      check($sformatf("sat%0d.cnt", k), conflict_cnt, 64'((k < 15) ? k : 15));
      next_cycle();
    end

    rand_phase(1500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
